packet_scheduler: RTL and testbench

Four-queue packet store and read-out scheduler for the key-entry path. Accepts 4-bit packets (2-bit destination, 2-bit payload) from the key-entry front end, stores them in four 6-deep queues with drop-oldest overflow, and drains one packet at a time on a fixed read period using round-robin arbitration. Sits between the key-entry stage and the display/consumer logic. Exposes flattened queue images and received/read/drop counters.

---
 rtl/packet_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_packet_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/packet_scheduler.sv
// rtl/packet_scheduler.sv - four-queue packet store with timed round-robin read-out
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   in_valid, in_data[3:0]   packet strobe; [3:2] queue select, [1:0] payload
//   rd_enable                1 = scheduler runs, 0 = reads paused and timer held at 0
//   out_valid/out_buf/out_payload  registered pop pulse, queue index and payload
//   buffer1_o..buffer4_o     queue images, entry i at [3i+2:3i] = {payload, valid}
//   received, reads, drops   saturating statistics counters
module packet_scheduler #(
    parameter int DEPTH       = 6,
    parameter int READ_PERIOD = 8,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [3:0]           in_data,
    input  logic                 rd_enable,
    output logic                 out_valid,
    output logic [1:0]           out_buf,
    output logic [1:0]           out_payload,
    output logic [3*DEPTH-1:0]   buffer1_o,
    output logic [3*DEPTH-1:0]   buffer2_o,
    output logic [3*DEPTH-1:0]   buffer3_o,
    output logic [3*DEPTH-1:0]   buffer4_o,
    output logic [CNT_W-1:0]     received,
    output logic [CNT_W-1:0]     reads,
    output logic [CNT_W-1:0]     drops
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int TMR_W = $clog2(READ_PERIOD);
    localparam logic [OCC_W-1:0] FULL      = OCC_W'(DEPTH);
    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(READ_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, COUNT, SERVE} state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [1:0]          last_q, last_d;
    logic [2:0]          q_q [4][DEPTH];
    logic [2:0]          q_d [4][DEPTH];
    logic [OCC_W-1:0]    occ_q [4];
    logic [OCC_W-1:0]    occ_d [4];
    logic                out_valid_q;
    logic [1:0]          out_buf_q, out_payload_q;
    logic [CNT_W-1:0]    received_q, received_d;
    logic [CNT_W-1:0]    reads_q, reads_d;
    logic [CNT_W-1:0]    drops_q, drops_d;

    logic                pop, drop, any_ready;
    logic [1:0]          grant, cand;
    logic [2:0]          entry;

    assign entry = {in_data[1:0], 1'b1};

    // Round-robin: scan starting one past the last served queue.
    always_comb begin
        grant     = '0;
        any_ready = 1'b0;
        cand      = '0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!any_ready && occ_q[cand] != '0) begin
                any_ready = 1'b1;
                grant     = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (rd_enable) state_d = COUNT;
            end
            COUNT: begin
                if (!rd_enable) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == LAST_TICK) begin
                    // Period expired: pop if anything is waiting, otherwise start a new period.
                    timer_d = '0;
                    if (any_ready) begin
                        pop     = 1'b1;
                        state_d = SERVE;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            SERVE: begin
                timer_d = '0;
                state_d = rd_enable ? COUNT : IDLE;
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign last_d = pop ? grant : last_q;

    // Queue update: pop shifts down first, so a same-edge write lands at the old count-1
    // and can never overflow.
    always_comb begin
        drop = 1'b0;
        for (int k = 0; k < 4; k++) begin
            q_d[k]   = q_q[k];
            occ_d[k] = occ_q[k];
            if (pop && grant == 2'(k)) begin
                for (int i = 0; i < DEPTH - 1; i++) q_d[k][i] = q_q[k][i+1];
                q_d[k][DEPTH-1] = '0;
                if (in_valid && in_data[3:2] == 2'(k)) begin
                    for (int i = 0; i < DEPTH; i++)
                        if (i == int'(occ_q[k]) - 1) q_d[k][i] = entry;
                end else begin
                    occ_d[k] = occ_q[k] - OCC_W'(1);
                end
            end else if (in_valid && in_data[3:2] == 2'(k)) begin
                if (occ_q[k] == FULL) begin
                    for (int i = 0; i < DEPTH - 1; i++) q_d[k][i] = q_q[k][i+1];
                    q_d[k][DEPTH-1] = entry;
                    drop = 1'b1;
                end else begin
                    for (int i = 0; i < DEPTH; i++)
                        if (i == int'(occ_q[k])) q_d[k][i] = entry;
                    occ_d[k] = occ_q[k] + OCC_W'(1);
                end
            end
        end
    end

    assign received_d = (in_valid && received_q != '1) ? received_q + CNT_W'(1) : received_q;
    assign reads_d    = (pop && reads_q != '1)         ? reads_q + CNT_W'(1)    : reads_q;
    assign drops_d    = (drop && drops_q != '1)        ? drops_q + CNT_W'(1)    : drops_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            last_q        <= 2'd3;
            out_valid_q   <= 1'b0;
            out_buf_q     <= '0;
            out_payload_q <= '0;
            received_q    <= '0;
            reads_q       <= '0;
            drops_q       <= '0;
            for (int k = 0; k < 4; k++) begin
                occ_q[k] <= '0;
                for (int i = 0; i < DEPTH; i++) q_q[k][i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            last_q      <= last_d;
            out_valid_q <= pop;
            if (pop) begin
                out_buf_q     <= grant;
                out_payload_q <= q_q[grant][0][2:1];
            end
            received_q  <= received_d;
            reads_q     <= reads_d;
            drops_q     <= drops_d;
            q_q         <= q_d;
            occ_q       <= occ_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_img
        assign buffer1_o[3*i +: 3] = q_q[0][i];
        assign buffer2_o[3*i +: 3] = q_q[1][i];
        assign buffer3_o[3*i +: 3] = q_q[2][i];
        assign buffer4_o[3*i +: 3] = q_q[3][i];
    end

    assign out_valid   = out_valid_q;
    assign out_buf     = out_buf_q;
    assign out_payload = out_payload_q;
    assign received    = received_q;
    assign reads       = reads_q;
    assign drops       = drops_q;

endmodule

// File: tb/tb_packet_scheduler.sv
// tb/tb_packet_scheduler.sv - directed vector bench for packet_scheduler
module tb_packet_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        rd_enable;
    logic        out_valid;
    logic [1:0]  out_buf;
    logic [1:0]  out_payload;
    logic [17:0] buffer1_o, buffer2_o, buffer3_o, buffer4_o;
    logic [7:0]  received, reads, drops;

    int checks = 0;
    int errors = 0;

    packet_scheduler dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .rd_enable(rd_enable),
        .out_valid(out_valid), .out_buf(out_buf), .out_payload(out_payload),
        .buffer1_o(buffer1_o), .buffer2_o(buffer2_o), .buffer3_o(buffer3_o), .buffer4_o(buffer4_o),
        .received(received), .reads(reads), .drops(drops)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  din;
        int          sel;
        logic [17:0] img;
        int          recv;
        int          drp;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] img_of(input int s);
        case (s)
            1: return buffer1_o;
            2: return buffer2_o;
            3: return buffer3_o;
            default: return buffer4_o;
        endcase
    endfunction

    task automatic wait_pop(input int limit, output int n);
        n = -1;
        for (int c = 1; c <= limit; c++) begin
            tick();
            if (out_valid) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic apply_vec(input int idx);
        in_valid = 1'b1;
        in_data  = vecs[idx].din;
        tick();
        check($sformatf("vec%0d_img", idx), 32'(img_of(vecs[idx].sel)), 32'(vecs[idx].img));
        check($sformatf("vec%0d_recv", idx), 32'(received), vecs[idx].recv);
        check($sformatf("vec%0d_drops", idx), 32'(drops), vecs[idx].drp);
        check($sformatf("vec%0d_nopop", idx), 32'(out_valid), 32'd0);
    endtask

    int n;
    int pops;
    int pop_t [4];
    int pop_b [4];
    int pop_p [4];
    logic seen;

    initial begin
        // one packet per queue after a reset
        vecs[0]  = '{4'b0010, 1, 18'h00005, 1, 0};
        vecs[1]  = '{4'b0111, 2, 18'h00007, 2, 0};
        vecs[2]  = '{4'b1001, 3, 18'h00003, 3, 0};
        vecs[3]  = '{4'b1100, 4, 18'h00001, 4, 0};
        // q1 filled back-to-back, seventh write overflows
        vecs[4]  = '{4'b0000, 1, 18'h00001, 5, 0};
        vecs[5]  = '{4'b0001, 1, 18'h00019, 6, 0};
        vecs[6]  = '{4'b0010, 1, 18'h00159, 7, 0};
        vecs[7]  = '{4'b0011, 1, 18'h00F59, 8, 0};
        vecs[8]  = '{4'b0000, 1, 18'h01F59, 9, 0};
        vecs[9]  = '{4'b0001, 1, 18'h19F59, 10, 0};
        vecs[10] = '{4'b0010, 1, 18'h2B3EB, 11, 1};

        // reset held two cycles with traffic on the inputs
        rst = 1'b1; in_valid = 1'b1; in_data = 4'b0110; rd_enable = 1'b1;
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_buf", 32'(out_buf), 0);
        check("rst_out_payload", 32'(out_payload), 0);
        check("rst_buf1", 32'(buffer1_o), 0);
        check("rst_buf2", 32'(buffer2_o), 0);
        check("rst_buf3", 32'(buffer3_o), 0);
        check("rst_buf4", 32'(buffer4_o), 0);
        check("rst_received", 32'(received), 0);
        check("rst_reads", 32'(reads), 0);
        check("rst_drops", 32'(drops), 0);
        rst = 1'b0; in_valid = 1'b0; rd_enable = 1'b0;
        tick();
        check("post_rst_received", 32'(received), 0);

        // single packet path
        in_valid = 1'b1; in_data = 4'b0110;
        tick();
        in_valid = 1'b0;
        check("single_buf2", 32'(buffer2_o), 32'h00005);
        check("single_received", 32'(received), 1);
        rd_enable = 1'b1;
        wait_pop(20, n);
        check("single_latency", n, 9);
        check("single_out_buf", 32'(out_buf), 1);
        check("single_payload", 32'(out_payload), 2);
        check("single_buf2_empty", 32'(buffer2_o), 0);
        check("single_reads", 32'(reads), 1);
        rd_enable = 1'b0;
        tick();
        check("single_pulse_end", 32'(out_valid), 0);
        check("single_buf_hold", 32'(out_buf), 1);
        check("single_payload_hold", 32'(out_payload), 2);

        // reset so the round-robin pointer starts at 3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) apply_vec(i);
        in_valid = 1'b0;

        // round-robin drain
        rd_enable = 1'b1;
        pops = 0;
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (out_valid) begin
                if (pops < 4) begin
                    pop_t[pops] = t;
                    pop_b[pops] = int'(out_buf);
                    pop_p[pops] = int'(out_payload);
                end
                pops++;
            end
        end
        check("rr_pop_count", pops, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_time%0d", i), pop_t[i], 9 * (i + 1));
            check($sformatf("rr_buf%0d", i), pop_b[i], i);
        end
        check("rr_pay0", pop_p[0], 2);
        check("rr_pay1", pop_p[1], 3);
        check("rr_pay2", pop_p[2], 1);
        check("rr_pay3", pop_p[3], 0);
        check("rr_reads", 32'(reads), 4);
        rd_enable = 1'b0;
        tick(); tick();

        // overflow on q1
        for (int i = 4; i < 11; i++) apply_vec(i);
        in_valid = 1'b0;

        // pop of q1 and a write to q1 on the same edge
        rd_enable = 1'b1;
        tick();
        seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("sim_early_pop", 32'(seen), 0);
        in_valid = 1'b1; in_data = 4'b0011;
        tick();
        in_valid = 1'b0;
        check("sim_out_valid", 32'(out_valid), 1);
        check("sim_out_buf", 32'(out_buf), 0);
        check("sim_payload", 32'(out_payload), 1);
        check("sim_drops", 32'(drops), 1);
        check("sim_received", 32'(received), 12);
        check("sim_buf1", 32'(buffer1_o), 32'h3D67D);
        check("sim_reads", 32'(reads), 5);
        rd_enable = 1'b0;
        tick();

        // pause mid-COUNT, timer restarts on re-enable
        rd_enable = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rd_enable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("pause_no_pop", 32'(seen), 0);
        rd_enable = 1'b1;
        wait_pop(20, n);
        check("pause_latency", n, 9);
        check("pause_out_buf", 32'(out_buf), 0);
        check("pause_payload", 32'(out_payload), 2);
        check("pause_buf1", 32'(buffer1_o), 32'h07ACF);
        check("pause_reads", 32'(reads), 6);

        // reset during SERVE
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("srst_out_valid", 32'(out_valid), 0);
        check("srst_out_buf", 32'(out_buf), 0);
        check("srst_payload", 32'(out_payload), 0);
        check("srst_buf1", 32'(buffer1_o), 0);
        check("srst_received", 32'(received), 0);
        check("srst_reads", 32'(reads), 0);
        check("srst_drops", 32'(drops), 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("srst_empty_no_pop", 32'(seen), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
